// File: rtl/common.sv
// Shared raster command types and the queued entry payload.
package common;

    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_PIXEL = 3'd1,
        CMD_LINE  = 3'd2,
        CMD_RECT  = 3'd3,
        CMD_FILL  = 3'd4,
        CMD_CLEAR = 3'd5
    } raster_command_t;

    typedef struct packed {
        raster_command_t       command;
        logic [COORD_W-1:0]    x0;
        logic [COORD_W-1:0]    y0;
        logic [COORD_W-1:0]    x1;
        logic [COORD_W-1:0]    y1;
        logic [COLOUR_W-1:0]   colour;
    } raster_entry_t;

endpackage

// File: rtl/rasterizer_if.sv
// Command handshake between the CPU-side queue and the rasterizer.
interface rasterizer_if;

    common::raster_command_t          command;
    logic [common::COORD_W-1:0]       x0;
    logic [common::COORD_W-1:0]       y0;
    logic [common::COORD_W-1:0]       x1;
    logic [common::COORD_W-1:0]       y1;
    logic [common::COLOUR_W-1:0]      colour;
    logic                             execute_request;
    logic                             busy;

    modport cpu (
        output command, x0, y0, x1, y1, colour, execute_request,
        input  busy
    );

    modport gpu (
        input  command, x0, y0, x1, y1, colour, execute_request,
        output busy
    );

endinterface

// File: rtl/raster_fifo.sv
// Synchronous FIFO of raster entries with a sticky overflow flag.
module raster_fifo
    import common::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  raster_entry_t             wr_data,
    output raster_entry_t             rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    raster_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic w_wr_en;
    logic w_rd_en;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (push && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign overflow = r_overflow;

endmodule

// File: rtl/raster_cmd_queue.sv
// CPU-side raster command queue: buffers commands and issues them to the
// rasterizer one at a time, leaving a guard cycle for busy to rise.
module raster_cmd_queue
    import common::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  raster_command_t           cmd_in,
    input  logic [7:0]                x0_in,
    input  logic [7:0]                y0_in,
    input  logic [7:0]                x1_in,
    input  logic [7:0]                y1_in,
    input  logic [2:0]                colour_in,
    input  logic                      push,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      idle,
    rasterizer_if.cpu                 gpu_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t         r_state;
    raster_entry_t  w_wr_entry;
    raster_entry_t  w_head;
    logic           w_exec;

    assign w_wr_entry = '{command: cmd_in, x0: x0_in, y0: y0_in,
                          x1: x1_in, y1: y1_in, colour: colour_in};

    raster_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (w_exec),
        .wr_data  (w_wr_entry),
        .rd_data  (w_head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // A late busy or a reset in ISSUE withholds the request; the entry stays queued.
    assign w_exec = (r_state == ST_ISSUE) && !rst && !gpu_if.busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= (!empty && !gpu_if.busy) ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: r_state <= ST_GUARD;
                ST_GUARD: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign idle = empty && (r_state == ST_IDLE) && !gpu_if.busy;

    assign gpu_if.execute_request = w_exec;
    assign gpu_if.command         = w_head.command;
    assign gpu_if.x0              = w_head.x0;
    assign gpu_if.y0              = w_head.y0;
    assign gpu_if.x1              = w_head.x1;
    assign gpu_if.y1              = w_head.y1;
    assign gpu_if.colour          = w_head.colour;

endmodule
